// File: rtl/display_value_scheduler_if.sv
// Producer/display bundle for the display value scheduler: three value
// producers on one side, the BCD display path on the other.
interface display_value_scheduler_if;
  // Producer side
  logic        a_valid;
  logic [13:0] a_value;
  logic        b_valid;
  logic [13:0] b_value;
  logic        sum_valid;
  logic [13:0] sum_value;
  // Display side
  logic [15:0] bcd_digits;
  logic [3:0]  blank_mask;
  logic [1:0]  src_tag;
  logic        overflow;
  logic        update;
  logic        busy;

  modport master (
    output a_valid, a_value, b_valid, b_value, sum_valid, sum_value,
    input  bcd_digits, blank_mask, src_tag, overflow, update, busy
  );

  modport slave (
    input  a_valid, a_value, b_valid, b_value, sum_valid, sum_value,
    output bcd_digits, blank_mask, src_tag, overflow, update, busy
  );
endinterface

// File: rtl/display_value_scheduler.sv
// Picks one pending producer value at a time (sum > B > A), saturates it to
// four decimal digits and converts it to BCD with a sequential double-dabble.
// Display outputs only change on the final cycle of a conversion.
module display_value_scheduler #(
  parameter int unsigned SHIFT_STEPS = 14,
  parameter int unsigned MAX_VALUE   = 9999
) (
  input  logic                       clk,
  input  logic                       reset,
  display_value_scheduler_if.slave   bus
);

  localparam logic [4:0]  LastStep = 5'(SHIFT_STEPS - 1);
  localparam logic [13:0] MaxVal   = 14'(MAX_VALUE);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Source tags as seen on src_tag
  localparam logic [1:0] TagNone = 2'b00;
  localparam logic [1:0] TagA    = 2'b01;
  localparam logic [1:0] TagB    = 2'b10;
  localparam logic [1:0] TagSum  = 2'b11;

  // Per-source request state
  logic        r_pend_a, r_pend_b, r_pend_sum;
  logic [13:0] r_hold_a, r_hold_b, r_hold_sum;

  // Conversion state
  state_e      r_state;
  logic [4:0]  r_step;
  logic [15:0] r_bcd;
  logic [13:0] r_bin;
  logic [1:0]  r_tag_scr;
  logic        r_ovf_scr;

  // Registered display outputs
  logic [15:0] r_bcd_digits;
  logic [3:0]  r_blank_mask;
  logic [1:0]  r_src_tag;
  logic        r_overflow;
  logic        r_update;
  logic        r_busy;

  // Grant / load path
  logic        w_idle;
  logic        w_grant_a, w_grant_b, w_grant_sum, w_any_grant;
  logic [13:0] w_sel_value;
  logic [1:0]  w_sel_tag;
  logic [13:0] w_load_value;
  logic        w_load_ovf;

  // Double-dabble step and blanking
  logic [15:0] w_bcd_adj;
  logic [15:0] w_bcd_next;
  logic [13:0] w_bin_next;
  logic [3:0]  w_blank;

  assign w_idle      = (r_state == StIdle);
  assign w_grant_sum = w_idle & r_pend_sum;
  assign w_grant_b   = w_idle & r_pend_b & ~r_pend_sum;
  assign w_grant_a   = w_idle & r_pend_a & ~r_pend_b & ~r_pend_sum;
  assign w_any_grant = w_grant_sum | w_grant_b | w_grant_a;

  // Select the granted hold value and its tag
  always_comb begin
    w_sel_value = '0;
    w_sel_tag   = TagNone;
    if (w_grant_sum) begin
      w_sel_value = r_hold_sum;
      w_sel_tag   = TagSum;
    end else if (w_grant_b) begin
      w_sel_value = r_hold_b;
      w_sel_tag   = TagB;
    end else if (w_grant_a) begin
      w_sel_value = r_hold_a;
      w_sel_tag   = TagA;
    end
  end

  // Values beyond four decimal digits are shown as the saturation limit
  always_comb begin
    w_load_ovf   = (w_sel_value > MaxVal);
    w_load_value = w_load_ovf ? MaxVal : w_sel_value;
  end

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift left
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    w_bcd_next = {w_bcd_adj[14:0], r_bin[13]};
    w_bin_next = {r_bin[12:0], 1'b0};
  end

  // Leading-zero blanking from the finished conversion; units never blanked
  always_comb begin
    w_blank    = 4'b0000;
    w_blank[3] = (r_bcd[15:12] == 4'd0);
    w_blank[2] = w_blank[3] & (r_bcd[11:8] == 4'd0);
    w_blank[1] = w_blank[2] & (r_bcd[7:4] == 4'd0);
    w_blank[0] = 1'b0;
  end

  // Pending flags and hold registers; a new valid wins over a same-edge grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_a   <= 1'b0;
      r_pend_b   <= 1'b0;
      r_pend_sum <= 1'b0;
      r_hold_a   <= '0;
      r_hold_b   <= '0;
      r_hold_sum <= '0;
    end else begin
      r_pend_a   <= (r_pend_a & ~w_grant_a) | bus.a_valid;
      r_pend_b   <= (r_pend_b & ~w_grant_b) | bus.b_valid;
      r_pend_sum <= (r_pend_sum & ~w_grant_sum) | bus.sum_valid;
      if (bus.a_valid) begin
        r_hold_a <= bus.a_value;
      end
      if (bus.b_valid) begin
        r_hold_b <= bus.b_value;
      end
      if (bus.sum_valid) begin
        r_hold_sum <= bus.sum_value;
      end
    end
  end

  // Conversion FSM with registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_step       <= '0;
      r_bcd        <= '0;
      r_bin        <= '0;
      r_tag_scr    <= TagNone;
      r_ovf_scr    <= 1'b0;
      r_bcd_digits <= '0;
      r_blank_mask <= 4'b1110;
      r_src_tag    <= TagNone;
      r_overflow   <= 1'b0;
      r_update     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_update <= 1'b0;
          if (w_any_grant) begin
            r_bcd     <= '0;
            r_bin     <= w_load_value;
            r_tag_scr <= w_sel_tag;
            r_ovf_scr <= w_load_ovf;
            r_step    <= '0;
            r_busy    <= 1'b1;
            r_state   <= StShift;
          end
        end
        StShift: begin
          r_bcd  <= w_bcd_next;
          r_bin  <= w_bin_next;
          r_step <= r_step + 5'd1;
          if (r_step == LastStep) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          r_bcd_digits <= r_bcd;
          r_blank_mask <= w_blank;
          r_src_tag    <= r_tag_scr;
          r_overflow   <= r_ovf_scr;
          r_update     <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.bcd_digits = r_bcd_digits;
  assign bus.blank_mask = r_blank_mask;
  assign bus.src_tag    = r_src_tag;
  assign bus.overflow   = r_overflow;
  assign bus.update     = r_update;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_display_value_scheduler.sv
// Scoreboard bench for display_value_scheduler: stimulus pushes expected
// display results; a negedge monitor pops and compares on every update.
module tb_display_value_scheduler;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  mask;
    logic [1:0]  tag;
    logic        ovf;
  } exp_t;

  logic clk;
  logic reset;
  display_value_scheduler_if ifc ();

  display_value_scheduler #(
    .SHIFT_STEPS (14),
    .MAX_VALUE   (9999)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_updates = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Decimal reference: saturate, split into digits, blank leading zeros
  function automatic exp_t model(input int unsigned val, input logic [1:0] tag);
    exp_t e;
    int unsigned v;
    v = (val > 9999) ? 9999 : val;
    e.digits = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    e.mask   = {(v < 1000), (v < 100), (v < 10), 1'b0};
    e.tag    = tag;
    e.ovf    = (val > 9999);
    return e;
  endfunction

  // Monitor: every update pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!reset && ifc.update) begin
      exp_t e, a;
      n_updates++;
      a = '{digits: ifc.bcd_digits, mask: ifc.blank_mask, tag: ifc.src_tag,
            ovf: ifc.overflow};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_update: got digits=%h mask=%b tag=%b ovf=%b, required none",
                 a.digits, a.mask, a.tag, a.ovf);
      end else begin
        e = exp_q.pop_front();
        if (a === e) n_pass++;
        else $display("FAIL update_%0d: got digits=%h mask=%b tag=%b ovf=%b, required digits=%h mask=%b tag=%b ovf=%b",
                      n_updates, a.digits, a.mask, a.tag, a.ovf, e.digits, e.mask, e.tag, e.ovf);
      end
    end
  end

  // Drive the selected valids for exactly one rising edge
  task automatic issue(input logic va, input int unsigned a, input logic vb, input int unsigned b,
                       input logic vs, input int unsigned s);
    @(negedge clk);
    ifc.a_valid   = va;
    ifc.a_value   = 14'(a);
    ifc.b_valid   = vb;
    ifc.b_value   = 14'(b);
    ifc.sum_valid = vs;
    ifc.sum_value = 14'(s);
    @(posedge clk);
    #1;
    ifc.a_valid   = 1'b0;
    ifc.b_valid   = 1'b0;
    ifc.sum_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || ifc.busy); i++) @(posedge clk);
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_digits"}, ifc.bcd_digits, 16'h0000);
    check({tagname, "_mask"},   ifc.blank_mask, 4'b1110);
    check({tagname, "_tag"},    ifc.src_tag, 2'b00);
    check({tagname, "_ovf"},    ifc.overflow, 1'b0);
    check({tagname, "_update"}, ifc.update, 1'b0);
    check({tagname, "_busy"},   ifc.busy, 1'b0);
  endtask

  function automatic int unsigned rand_value();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 9999;
      2:       return 10000;
      3:       return 16383;
      default: return $urandom_range(0, 16383);
    endcase
  endfunction

  initial begin
    int upd0;
    reset         = 1'b1;
    ifc.a_valid   = 1'b0;
    ifc.a_value   = '0;
    ifc.b_valid   = 1'b0;
    ifc.b_value   = '0;
    ifc.sum_valid = 1'b0;
    ifc.sum_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // A=12: latency of 16 edges and a single update pulse
    upd0 = n_updates;
    exp_q.push_back(model(12, 2'b01));
    issue(1, 12, 0, 0, 0, 0);
    repeat (15) @(posedge clk);
    #1;
    check("lat_update_early", ifc.update, 1'b0);
    check("lat_busy_mid", ifc.busy, 1'b1);
    @(posedge clk);
    #1;
    check("lat_update_e16", ifc.update, 1'b1);
    check("lat_busy_done", ifc.busy, 1'b0);
    wait_drain();
    repeat (20) @(posedge clk);
    check("a12_one_update", n_updates - upd0, 1);

    // Sum 999, then saturation and zero on B
    exp_q.push_back(model(999, 2'b11));
    issue(0, 0, 0, 0, 1, 999);
    wait_drain();
    exp_q.push_back(model(16383, 2'b10));
    issue(0, 0, 1, 16383, 0, 0);
    wait_drain();
    exp_q.push_back(model(0, 2'b10));
    issue(0, 0, 1, 0, 0, 0);
    wait_drain();

    // Simultaneous A and sum: sum first
    exp_q.push_back(model(5678, 2'b11));
    exp_q.push_back(model(34, 2'b01));
    issue(1, 34, 0, 0, 1, 5678);
    wait_drain();

    // Re-posts during conversion: latest value wins
    exp_q.push_back(model(100, 2'b01));
    exp_q.push_back(model(300, 2'b01));
    issue(1, 100, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    issue(1, 200, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    issue(1, 300, 0, 0, 0, 0);
    wait_drain();

    // Valid on the grant edge: old value converted, new value follows
    exp_q.push_back(model(50, 2'b01));
    exp_q.push_back(model(60, 2'b01));
    issue(1, 50, 0, 0, 0, 0);
    issue(1, 60, 0, 0, 0, 0);
    wait_drain();

    // Reset at step 7 of a conversion of 4321
    upd0 = n_updates;
    issue(1, 4321, 0, 0, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    check("midreset_no_update", n_updates - upd0, 0);
    exp_q.push_back(model(7, 2'b01));
    issue(1, 7, 0, 0, 0, 0);
    wait_drain();

    // Random bursts with an optional re-post of the first-served source
    for (int it = 0; it < 30; it++) begin
      logic [2:0]  sel;
      int unsigned va, vb, vs, vn;
      int          first;
      bit          repost;
      int          dly;
      sel = 3'($urandom_range(1, 7));
      va = rand_value();
      vb = rand_value();
      vs = rand_value();
      vn = rand_value();
      repost = ($urandom_range(0, 1) == 1);
      dly = $urandom_range(0, 14);
      first = sel[2] ? 2 : (sel[1] ? 1 : 0);
      if (sel[2]) begin
        exp_q.push_back(model(vs, 2'b11));
        if (repost) exp_q.push_back(model(vn, 2'b11));
      end
      if (sel[1]) begin
        exp_q.push_back(model(vb, 2'b10));
        if (repost && first == 1) exp_q.push_back(model(vn, 2'b10));
      end
      if (sel[0]) begin
        exp_q.push_back(model(va, 2'b01));
        if (repost && first == 0) exp_q.push_back(model(vn, 2'b01));
      end
      issue(sel[0], va, sel[1], vb, sel[2], vs);
      if (repost) begin
        repeat (dly) @(posedge clk);
        issue(first == 0, vn, first == 1, vn, first == 2, vn);
      end
      wait_drain();
    end

    repeat (40) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_value_scheduler.md
# display_value_scheduler

Schedules which value reaches the 7-segment display path and converts it to BCD. Three producers post 14-bit binary values: operand A entry, operand B entry and the adder result. A fixed-priority scheduler picks one pending value at a time and runs a sequential 14-step double-dabble conversion. It then presents four stable BCD digits, a leading-zero blank mask and a source tag to the display multiplexer.

## Interface

Parameters:
- `SHIFT_STEPS`, default 14. Number of double-dabble iterations; equals the input width.
- `MAX_VALUE`, default 9999. Saturation limit for four decimal digits.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  one-cycle pulse: new operand A value.
- `a_value`  in  14  operand A binary value.
- `b_valid`  in  1  one-cycle pulse: new operand B value.
- `b_value`  in  14  operand B binary value.
- `sum_valid`  in  1  one-cycle pulse: new sum value.
- `sum_value`  in  14  sum binary value.
- `bcd_digits`  out  16  BCD digits; [15:12] thousands … [3:0] units.
- `blank_mask`  out  4  1 = digit is a leading zero and is blanked. Bit 3 is thousands; bit 0 is always 0.
- `src_tag`  out  2  source of the displayed value: 00 none, 01 A, 10 B, 11 sum.
- `overflow`  out  1  displayed value was saturated.
- `update`  out  1  one-cycle pulse when the outputs change.
- `busy`  out  1  conversion in progress.

## Operation

- Per-source pending flag and 14-bit hold register, one pair for each of A, B and sum.
  - When a source's `*_valid` is sampled high, set its flag and overwrite its hold register with the new value. Latest value wins.
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**, when any pending flag is set:
  - Grant by fixed priority: sum > B > A.
  - Clear the granted flag.
  - Load the scratch shift register with the granted hold value, saturated to `MAX_VALUE` when greater. Record the overflow bit and the grant tag.
  - Step counter ← 0. Go to SHIFT.
- **SHIFT**, each cycle:
  - Add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - After step `SHIFT_STEPS` (counter = 13), go to DONE.
- **DONE**, for one cycle:
  - Register `bcd_digits`, `src_tag` and `overflow`.
  - Compute `blank_mask`: a digit is blanked when it and every higher digit are 0. The units digit is never blanked.
  - Pulse `update`. Return to IDLE.
- `*_valid` for a source while that same source is being converted: set the flag again. The source is reconverted afterwards with the new value.
- `*_valid` on the same edge as that source's grant: the set takes priority over the clear. The hold register takes the new value; the old value is the one being converted.
- Multiple simultaneous valids: all flags are set; they are served in priority order on successive conversions.
- Conversion arithmetic is done only on the scratch registers. The outputs hold their previous value until the DONE edge, so the display never shows partial digits.

## Timing

- Reset values:
  - `bcd_digits` = 0x0000
  - `blank_mask` = 4'b1110
  - `src_tag` = 00
  - `overflow` = 0, `update` = 0, `busy` = 0
  - FSM = IDLE, all pending flags and hold registers cleared
- A valid sampled at edge E0 sets pending.
  - At E1 the IDLE grant is taken.
  - E2–E15 perform the 14 shift steps.
  - At E16 (DONE) the outputs are registered and `update` is high for the cycle after E16.
  - Latency is 16 edges from valid to new outputs when idle.
- `busy` is high from after E1 through the DONE cycle, then low.
- Back-to-back conversions: the next IDLE grant is taken on the edge after DONE, so each conversion costs 16 cycles.
- Reset asserted mid-conversion: everything clears immediately and asynchronously, pending requests are dropped, and outputs return to reset values. There is no `update` pulse.

## Test plan

- Reset, then `a_valid` with `a_value`=12.
  - After 16 edges: `bcd_digits`=0x0012, `blank_mask`=1100, `src_tag`=01, `overflow`=0.
  - Exactly one `update` pulse.
- `sum_valid` with value 999 → `bcd_digits`=0x0999, `blank_mask`=1000, `src_tag`=11.
- `b_valid` with 16383 → `bcd_digits`=0x9999, `overflow`=1, `blank_mask`=0000. Then `b_valid` with 0 → 0x0000, `blank_mask`=1110.
- `a_valid`=34 and `sum_valid`=5678 on the same edge.
  - First update: 0x5678, tag 11.
  - 16 cycles later: 0x0034, tag 01.
- While A=100 is converting, pulse `a_valid` with 200, then 300.
  - First update shows 0x0100.
  - Next update shows 0x0300; 200 is never displayed.
- Assert `reset` at step 7 of a conversion of 4321.
  - Outputs return to reset values and no `update` pulse occurs.
  - After release, a new A=7 gives 0x0007 with `blank_mask`=1110.
